// File: rtl/coproc_axil_cmd_regs.sv
// AXI4-Lite register file with four argument registers, a status word and a
// command FIFO. Each write to REG3 snapshots all four registers into the FIFO.
module coproc_axil_cmd_regs #(
  parameter int C_S_AXI_DATA_WIDTH = 32,
  parameter int C_S_AXI_ADDR_WIDTH = 5,
  parameter int FIFO_DEPTH         = 4
) (
  input  logic                              S_AXI_ACLK,
  input  logic                              S_AXI_ARESET,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0]     S_AXI_AWADDR,
  input  logic [2:0]                        S_AXI_AWPROT,
  input  logic                              S_AXI_AWVALID,
  output logic                              S_AXI_AWREADY,
  input  logic [C_S_AXI_DATA_WIDTH-1:0]     S_AXI_WDATA,
  input  logic [C_S_AXI_DATA_WIDTH/8-1:0]   S_AXI_WSTRB,
  input  logic                              S_AXI_WVALID,
  output logic                              S_AXI_WREADY,
  output logic [1:0]                        S_AXI_BRESP,
  output logic                              S_AXI_BVALID,
  input  logic                              S_AXI_BREADY,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0]     S_AXI_ARADDR,
  input  logic [2:0]                        S_AXI_ARPROT,
  input  logic                              S_AXI_ARVALID,
  output logic                              S_AXI_ARREADY,
  output logic [C_S_AXI_DATA_WIDTH-1:0]     S_AXI_RDATA,
  output logic [1:0]                        S_AXI_RRESP,
  output logic                              S_AXI_RVALID,
  input  logic                              S_AXI_RREADY,
  output logic [4*C_S_AXI_DATA_WIDTH-1:0]   cmd_data,
  output logic                              cmd_valid,
  input  logic                              cmd_ready
);

  localparam int DW = C_S_AXI_DATA_WIDTH;
  localparam int SW = DW / 8;
  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = PW + 1;
  localparam int EW = 4 * DW;

  logic [DW-1:0] reg_q [4];

  logic          wr_acc_q;
  logic          bvalid_q;
  logic [1:0]    bresp_q;
  logic          arready_q;
  logic          rvalid_q;
  logic [DW-1:0] rdata_q;

  logic [EW-1:0] fifo_mem_q [FIFO_DEPTH];
  logic [PW-1:0] wptr_q;
  logic [PW-1:0] rptr_q;
  logic [PW-1:0] rptr_d;
  logic [CW-1:0] count_q;
  logic [CW-1:0] count_d;
  logic          ovf_q;
  logic [EW-1:0] cmd_data_q;
  logic [EW-1:0] cmd_data_d;

  logic [2:0]    wr_sel;
  logic [2:0]    rd_sel;
  logic          wr_en;
  logic [DW-1:0] wr_old;
  logic [DW-1:0] wr_merged;
  logic [EW-1:0] push_entry;
  logic          push_req;
  logic          push_ok;
  logic          push_rej;
  logic          pop;
  logic          ovf_clr;
  logic          fifo_full;
  logic          fifo_empty;
  logic [DW-1:0] status_word;
  logic [DW-1:0] rd_word;
  logic          unused_ok;

  assign unused_ok = ^{S_AXI_AWPROT, S_AXI_ARPROT, S_AXI_AWADDR, S_AXI_ARADDR};

  assign wr_sel     = S_AXI_AWADDR[4:2];
  assign rd_sel     = S_AXI_ARADDR[4:2];
  assign wr_en      = wr_acc_q;
  assign fifo_full  = (count_q == CW'(FIFO_DEPTH));
  assign fifo_empty = (count_q == '0);

  always_comb begin
    wr_old = wr_sel[2] ? '0 : reg_q[wr_sel[1:0]];
    for (int unsigned b = 0; b < SW; b++) begin
      wr_merged[8*b +: 8] = S_AXI_WSTRB[b] ? S_AXI_WDATA[8*b +: 8] : wr_old[8*b +: 8];
    end
  end

  assign push_entry = {wr_merged, reg_q[2], reg_q[1], reg_q[0]};
  assign push_req   = wr_en && (wr_sel == 3'd3);
  assign pop        = !fifo_empty && cmd_ready;
  assign push_ok    = push_req && (!fifo_full || pop);
  assign push_rej   = push_req && !push_ok;
  assign ovf_clr    = wr_en && (wr_sel == 3'd4) && S_AXI_WSTRB[2] && S_AXI_WDATA[16];

  assign rptr_d = pop ? rptr_q + PW'(1) : rptr_q;

  always_comb begin
    count_d = count_q;
    if (push_ok && !pop) begin
      count_d = count_q + CW'(1);
    end else if (!push_ok && pop) begin
      count_d = count_q - CW'(1);
    end
  end

  // Head register: when the entry being pushed lands at the new read pointer it
  // is taken directly, since the memory write only lands on this edge.
  always_comb begin
    cmd_data_d = cmd_data_q;
    if (count_d != '0) begin
      if (push_ok && (wptr_q == rptr_d)) begin
        cmd_data_d = push_entry;
      end else begin
        cmd_data_d = fifo_mem_q[rptr_d];
      end
    end
  end

  always_comb begin
    status_word       = '0;
    status_word[7:0]  = 8'(count_q);
    status_word[8]    = fifo_full;
    status_word[9]    = fifo_empty;
    status_word[16]   = ovf_q;
  end

  always_comb begin
    case (rd_sel)
      3'd0:    rd_word = reg_q[0];
      3'd1:    rd_word = reg_q[1];
      3'd2:    rd_word = reg_q[2];
      3'd3:    rd_word = reg_q[3];
      3'd4:    rd_word = status_word;
      default: rd_word = '0;
    endcase
  end

  always_ff @(posedge S_AXI_ACLK) begin
    if (push_ok) begin
      fifo_mem_q[wptr_q] <= push_entry;
    end
  end

  always_ff @(posedge S_AXI_ACLK) begin
    if (S_AXI_ARESET) begin
      for (int unsigned i = 0; i < 4; i++) begin
        reg_q[i] <= '0;
      end
      wr_acc_q   <= 1'b0;
      bvalid_q   <= 1'b0;
      bresp_q    <= '0;
      arready_q  <= 1'b0;
      rvalid_q   <= 1'b0;
      rdata_q    <= '0;
      wptr_q     <= '0;
      rptr_q     <= '0;
      count_q    <= '0;
      ovf_q      <= 1'b0;
      cmd_data_q <= '0;
    end else begin
      // AW and W are accepted together, one cycle after both are seen valid.
      wr_acc_q <= S_AXI_AWVALID && S_AXI_WVALID && !bvalid_q && !wr_acc_q;
      if (wr_acc_q) begin
        bvalid_q <= 1'b1;
        bresp_q  <= push_rej ? 2'b10 : 2'b00;
      end else if (bvalid_q && S_AXI_BREADY) begin
        bvalid_q <= 1'b0;
      end

      if (wr_en && !wr_sel[2]) begin
        reg_q[wr_sel[1:0]] <= wr_merged;
      end

      if (push_rej) begin
        ovf_q <= 1'b1;
      end else if (ovf_clr) begin
        ovf_q <= 1'b0;
      end

      if (push_ok) begin
        wptr_q <= wptr_q + PW'(1);
      end
      rptr_q     <= rptr_d;
      count_q    <= count_d;
      cmd_data_q <= cmd_data_d;

      arready_q <= S_AXI_ARVALID && !rvalid_q && !arready_q;
      if (arready_q) begin
        rvalid_q <= 1'b1;
        rdata_q  <= rd_word;
      end else if (rvalid_q && S_AXI_RREADY) begin
        rvalid_q <= 1'b0;
      end
    end
  end

  assign S_AXI_AWREADY = wr_acc_q;
  assign S_AXI_WREADY  = wr_acc_q;
  assign S_AXI_BVALID  = bvalid_q;
  assign S_AXI_BRESP   = bresp_q;
  assign S_AXI_ARREADY = arready_q;
  assign S_AXI_RVALID  = rvalid_q;
  assign S_AXI_RDATA   = rdata_q;
  assign S_AXI_RRESP   = 2'b00;
  assign cmd_data      = cmd_data_q;
  assign cmd_valid     = !fifo_empty;

endmodule
